// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl
// Turn sequencer for the 5x5 two-board battleship game. It owns both boards,
// the player cursor, the player-turn timer and the PC target generator.
// Optional build macro: CURSOR_WRAP_EN (cursor wraps at board edges instead
// of saturating at row/column 0 and 4).
//
// Pulse semantics: start and btn_* are single-cycle event pulses with no
// backpressure. Each asserted cycle is one event; an event arriving in a
// state that does not consume it is dropped, never queued.
module battleship_turn_ctrl #(
    parameter int unsigned TURN_TIMEOUT = 750000000,
    parameter int unsigned PC_DELAY     = 25000000,
    parameter logic [4:0]  LFSR_SEED    = 5'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] ships_player,
    input  logic [24:0] ships_pc,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    output logic [2:0]  i_actual,
    output logic [2:0]  j_actual,
    output logic [1:0]  tablero_jugador [0:4][0:4],
    output logic [1:0]  tablero_pc [0:4][0:4],
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [29:0] timeout_left,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_TURN  = 3'd1,
        P_SHOT  = 3'd2,
        PC_WAIT = 3'd3,
        PC_PICK = 3'd4,
        PC_SHOT = 3'd5,
        WIN     = 3'd6,
        LOSE    = 3'd7
    } state_t;

    localparam logic [1:0]  CELL_WATER   = 2'd0;
    localparam logic [1:0]  CELL_SHIP    = 2'd1;
    localparam logic [1:0]  CELL_MISS    = 2'd2;
    localparam logic [1:0]  CELL_HIT     = 2'd3;
    localparam logic [29:0] TIMEOUT_LOAD = 30'(TURN_TIMEOUT);
    localparam logic [29:0] DELAY_LOAD   = 30'(PC_DELAY);

    state_t      state;
    state_t      state_next;

    // Boards stored flat, cell index = 5*row + col.
    logic [1:0]  board_p [0:24];
    logic [1:0]  board_c [0:24];

    logic [4:0]  ships_p_cnt;
    logic [4:0]  ships_c_cnt;
    logic [4:0]  hits_p;
    logic [4:0]  hits_c;
    logic [29:0] delay_cnt;
    logic [4:0]  lfsr;
    logic [4:0]  tries;
    logic [4:0]  scan_idx;
    logic [4:0]  pc_target;

    logic [4:0]  cur_idx;
    logic [1:0]  aim_cell;
    logic        fire_ok;
    logic        load_game;
    logic [4:0]  lfsr_idx;
    logic [4:0]  cand_idx;
    logic        cand_free;
    logic [1:0]  pc_cell;
    logic [4:0]  hits_p_new;
    logic [4:0]  hits_c_new;

    // Index successor modulo 25, used by the fallback linear scan.
    function automatic logic [4:0] idx_next(input logic [4:0] v);
        return (v == 5'd24) ? 5'd0 : v + 5'd1;
    endfunction

    // Cursor step towards row/col 0.
    function automatic logic [2:0] pos_dec(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return (v == 3'd0) ? 3'd4 : v - 3'd1;
`else
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
`endif
    endfunction

    // Cursor step towards row/col 4.
    function automatic logic [2:0] pos_inc(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
`else
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
`endif
    endfunction

    assign dbg_state = state;

    // Shared decode: aimed cell, PC candidate cell and post-shot hit counts.
    always_comb begin
        cur_idx    = ({2'b00, i_actual} * 5'd5) + {2'b00, j_actual};
        aim_cell   = board_c[cur_idx];
        fire_ok    = btn_fire && !aim_cell[1];
        load_game  = (state inside {IDLE, WIN, LOSE}) && start
                     && (|ships_player) && (|ships_pc);
        lfsr_idx   = (lfsr >= 5'd25) ? lfsr - 5'd25 : lfsr;
        cand_idx   = (tries < 5'd25) ? lfsr_idx : scan_idx;
        cand_free  = !board_p[cand_idx][1];
        pc_cell    = board_p[pc_target];
        hits_p_new = hits_p + {4'b0000, aim_cell == CELL_SHIP};
        hits_c_new = hits_c + {4'b0000, pc_cell == CELL_SHIP};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the game sequence.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, WIN, LOSE: begin
                if (load_game) state_next = P_TURN;
            end
            P_TURN: begin
                if (fire_ok)                      state_next = P_SHOT;
                else if (timeout_left <= 30'd1)   state_next = PC_WAIT;
            end
            P_SHOT: begin
                state_next = (hits_p_new == ships_c_cnt) ? WIN : PC_WAIT;
            end
            PC_WAIT: begin
                if (delay_cnt <= 30'd1) state_next = PC_PICK;
            end
            PC_PICK: begin
                if (cand_free) state_next = PC_SHOT;
            end
            PC_SHOT: begin
                state_next = (hits_c_new == ships_p_cnt) ? LOSE : P_TURN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Board contents, ship counts and hit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 25; k++) begin
                board_p[k] <= CELL_WATER;
                board_c[k] <= CELL_WATER;
            end
            ships_p_cnt <= '0;
            ships_c_cnt <= '0;
            hits_p      <= '0;
            hits_c      <= '0;
        end else if (load_game) begin
            for (int k = 0; k < 25; k++) begin
                board_p[k] <= {1'b0, ships_player[k]};
                board_c[k] <= {1'b0, ships_pc[k]};
            end
            ships_p_cnt <= 5'($countones(ships_player));
            ships_c_cnt <= 5'($countones(ships_pc));
            hits_p      <= '0;
            hits_c      <= '0;
        end else if (state == P_SHOT) begin
            board_c[cur_idx] <= aim_cell[0] ? CELL_HIT : CELL_MISS;
            hits_p           <= hits_p_new;
        end else if (state == PC_SHOT) begin
            board_p[pc_target] <= pc_cell[0] ? CELL_HIT : CELL_MISS;
            hits_c             <= hits_c_new;
        end
    end

    // Player cursor: reset on game load, moves only on the player's turn;
    // a fire pulse suppresses movement in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_actual <= '0;
            j_actual <= '0;
        end else if (load_game) begin
            i_actual <= '0;
            j_actual <= '0;
        end else if (state == P_TURN && !btn_fire) begin
            if (btn_up)         i_actual <= pos_dec(i_actual);
            else if (btn_down)  i_actual <= pos_inc(i_actual);
            else if (btn_left)  j_actual <= pos_dec(j_actual);
            else if (btn_right) j_actual <= pos_inc(j_actual);
        end
    end

    // Player-turn timer and PC visible-delay counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_left <= '0;
            delay_cnt    <= '0;
        end else begin
            if (load_game) begin
                timeout_left <= TIMEOUT_LOAD;
            end else if (state == PC_SHOT && state_next == P_TURN) begin
                timeout_left <= TIMEOUT_LOAD;
            end else if (state == P_TURN && timeout_left != '0) begin
                timeout_left <= timeout_left - 30'd1;
            end

            if (state != PC_WAIT && state_next == PC_WAIT) begin
                delay_cnt <= DELAY_LOAD;
            end else if (state == PC_WAIT && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - 30'd1;
            end
        end
    end

    // PC target selection: LFSR (x^5+x^3+1) candidates for 25 tries, then a
    // linear scan that always finds an unshot cell while the game is live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            tries     <= '0;
            scan_idx  <= '0;
            pc_target <= '0;
        end else if (state == PC_PICK) begin
            lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
            if (cand_free) begin
                pc_target <= cand_idx;
            end else if (tries < 5'd25) begin
                tries <= tries + 5'd1;
                if (tries == 5'd24) scan_idx <= idx_next(cand_idx);
            end else begin
                scan_idx <= idx_next(scan_idx);
            end
        end else begin
            tries <= '0;
        end
    end

    // Registered status outputs, aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn       <= 1'b0;
            game_state <= 2'd0;
        end else begin
            turn <= (state_next inside {PC_WAIT, PC_PICK, PC_SHOT});
            unique case (state_next)
                IDLE:    game_state <= 2'd0;
                WIN:     game_state <= 2'd2;
                LOSE:    game_state <= 2'd3;
                default: game_state <= 2'd1;
            endcase
        end
    end

    // Present the flat boards as row/column arrays for the video generator.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                tablero_jugador[r][c] = board_p[5*r + c];
                tablero_pc[r][c]      = board_c[5*r + c];
            end
        end
    end

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Testbench for battleship_turn_ctrl with a short turn timeout and PC delay.
module tb_battleship_turn_ctrl;

    localparam int TT = 20;
    localparam int PD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] ships_player;
    logic [24:0] ships_pc;
    logic        btn_up, btn_down, btn_left, btn_right, btn_fire;
    logic [2:0]  i_actual, j_actual;
    logic [1:0]  tab_j [0:4][0:4];
    logic [1:0]  tab_p [0:4][0:4];
    logic        turn;
    logic [1:0]  game_state;
    logic [29:0] timeout_left;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int model_j [25];
    int model_p [25];

    battleship_turn_ctrl #(.TURN_TIMEOUT(TT), .PC_DELAY(PD), .LFSR_SEED(5'h15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ships_player(ships_player), .ships_pc(ships_pc),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_fire(btn_fire),
        .i_actual(i_actual), .j_actual(j_actual),
        .tablero_jugador(tab_j), .tablero_pc(tab_p),
        .turn(turn), .game_state(game_state),
        .timeout_left(timeout_left), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Reference cursor rules
    function automatic int dec_pos(input int v);
`ifdef CURSOR_WRAP_EN
        return (v == 0) ? 4 : v - 1;
`else
        return (v == 0) ? 0 : v - 1;
`endif
    endfunction

    function automatic int inc_pos(input int v);
`ifdef CURSOR_WRAP_EN
        return (v == 4) ? 0 : v + 1;
`else
        return (v == 4) ? 4 : v + 1;
`endif
    endfunction

    function automatic int diff_j();
        int n = 0;
        for (int k = 0; k < 25; k++) if (tab_j[k/5][k%5] !== 2'(model_j[k])) n++;
        return n;
    endfunction

    function automatic int diff_p();
        int n = 0;
        for (int k = 0; k < 25; k++) if (tab_p[k/5][k%5] !== 2'(model_p[k])) n++;
        return n;
    endfunction

    task automatic load_model(input logic [24:0] pm, input logic [24:0] cm);
        for (int k = 0; k < 25; k++) begin
            model_j[k] = pm[k] ? 1 : 0;
            model_p[k] = cm[k] ? 1 : 0;
        end
    endtask

    // Driver tasks: inputs change just after a falling edge.
    task automatic clear_inputs();
        start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ships_player = '0; ships_pc = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        load_model('0, '0);
    endtask

    task automatic pulse(input logic up, input logic dn, input logic lf,
                         input logic rt, input logic fi);
        btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt; btn_fire = fi;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic start_game(input logic [24:0] pm, input logic [24:0] cm);
        ships_player = pm; ships_pc = cm;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset();
        logic [24:0] pm, cm;
        rst = 1; clear_inputs(); ships_player = '0; ships_pc = '0;
        #1;
        load_model('0, '0);
        checks++;
        if (i_actual !== 0 || j_actual !== 0 || turn !== 0 || game_state !== 0 ||
            timeout_left !== 0 || diff_j() != 0 || diff_p() != 0)
        begin
            errors++;
            $display("FAIL reset_initial: cur=(%0d,%0d) turn=%b gs=%0d to=%0d dj=%0d dp=%0d want all zero",
                     i_actual, j_actual, turn, game_state, timeout_left, diff_j(), diff_p());
        end
        @(negedge clk); rst = 0; @(negedge clk);
        pm = 25'($urandom) | 25'h3;
        cm = 25'($urandom) | 25'h3;
        start_game(pm, cm);
        load_model(pm, cm);
        checks++;
        if (game_state !== 2'd1 || turn !== 0 || timeout_left !== 30'(TT) ||
            diff_j() != 0 || diff_p() != 0)
        begin
            errors++;
            $display("FAIL start_load: gs=%0d turn=%b to=%0d dj=%0d dp=%0d want gs=1 turn=0 to=%0d boards=masks",
                     game_state, turn, timeout_left, diff_j(), diff_p(), TT);
        end
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        checks++;
        if (i_actual !== 3'd1 || j_actual !== 3'd1) begin
            errors++;
            $display("FAIL move_before_reset: cur=(%0d,%0d) want (1,1)", i_actual, j_actual);
        end
        rst = 1;
        #1;
        load_model('0, '0);
        checks++;
        if (i_actual !== 0 || j_actual !== 0 || turn !== 0 || game_state !== 0 ||
            timeout_left !== 0 || diff_j() != 0 || diff_p() != 0)
        begin
            errors++;
            $display("FAIL reset_async: cur=(%0d,%0d) turn=%b gs=%0d to=%0d dj=%0d dp=%0d want zero",
                     i_actual, j_actual, turn, game_state, timeout_left, diff_j(), diff_p());
        end
        @(negedge clk);
        checks++;
        if (i_actual !== 0 || j_actual !== 0 || game_state !== 0 || turn !== 0 || diff_p() != 0) begin
            errors++;
            $display("FAIL reset_held: cur=(%0d,%0d) gs=%0d turn=%b dp=%0d want zero",
                     i_actual, j_actual, game_state, turn, diff_p());
        end
        rst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (i_actual !== 0 || j_actual !== 0 || game_state !== 0 || turn !== 0 ||
            timeout_left !== 0 || diff_j() != 0 || diff_p() != 0)
        begin
            errors++;
            $display("FAIL reset_released: cur=(%0d,%0d) gs=%0d turn=%b to=%0d want zero/idle",
                     i_actual, j_actual, game_state, turn, timeout_left);
        end
    endtask

    task automatic test_start_ignored();
        do_reset();
        start_game(25'($urandom) | 25'h1, 25'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (game_state !== 0 || timeout_left !== 0 || diff_j() != 0 || diff_p() != 0) begin
            errors++;
            $display("FAIL start_pc_mask_zero: gs=%0d to=%0d dj=%0d want idle, boards zero",
                     game_state, timeout_left, diff_j());
        end
        start_game(25'd0, 25'($urandom) | 25'h1);
        repeat (2) @(negedge clk);
        checks++;
        if (game_state !== 0 || timeout_left !== 0 || diff_j() != 0 || diff_p() != 0) begin
            errors++;
            $display("FAIL start_player_mask_zero: gs=%0d to=%0d dp=%0d want idle, boards zero",
                     game_state, timeout_left, diff_p());
        end
    endtask

    task automatic test_timeout_pc_shot();
        logic [24:0] pm, cm;
        int n;
        do_reset();
        pm = 25'($urandom) | 25'h3;
        cm = 25'($urandom) | 25'h3;
        start_game(pm, cm);
        load_model(pm, cm);
        for (int k = 1; k <= TT; k++) begin
            @(negedge clk);
            checks++;
            if (timeout_left !== 30'(TT - k) || turn !== (k == TT)) begin
                errors++;
                $display("FAIL turn_timer k=%0d: to=%0d turn=%b want to=%0d turn=%b",
                         k, timeout_left, turn, TT - k, (k == TT));
            end
        end
        n = 0;
        while (turn === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        // Fresh LFSR seed 0x15 = 21 -> first candidate row 4, col 1, unshot.
        model_j[21] = (model_j[21] == 1) ? 3 : 2;
        checks++;
        if (n != PD + 2) begin
            errors++;
            $display("FAIL pc_turn_length: pc cycles=%0d want %0d", n, PD + 2);
        end
        checks++;
        if (diff_j() != 0 || tab_j[4][1] !== 2'(model_j[21])) begin
            errors++;
            $display("FAIL pc_first_shot: cell(4,1)=%0d diff=%0d want cell=%0d only change",
                     tab_j[4][1], diff_j(), model_j[21]);
        end
        checks++;
        if (turn !== 0 || timeout_left !== 30'(TT) || game_state !== 2'd1) begin
            errors++;
            $display("FAIL back_to_player: turn=%b to=%0d gs=%0d want 0 %0d 1",
                     turn, timeout_left, game_state, TT);
        end
    endtask

    task automatic test_cursor();
        logic [24:0] pm, cm;
        int ei, ej, idx;
        do_reset();
        pm = 25'($urandom) | 25'h7;
        cm = 25'($urandom) | 25'h3;
        start_game(pm, cm);
        load_model(pm, cm);
        ei = dec_pos(0); ej = 0;
        pulse(1, 0, 0, 0, 0);
        checks++;
        if (i_actual !== 3'(ei) || j_actual !== 3'(ej)) begin
            errors++;
            $display("FAIL cursor_up_edge: cur=(%0d,%0d) want (%0d,%0d)", i_actual, j_actual, ei, ej);
        end
        ej = dec_pos(0);
        pulse(0, 0, 1, 0, 0);
        checks++;
        if (i_actual !== 3'(ei) || j_actual !== 3'(ej)) begin
            errors++;
            $display("FAIL cursor_left_edge: cur=(%0d,%0d) want (%0d,%0d)", i_actual, j_actual, ei, ej);
        end
        for (int n = 0; n < 12; n++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            if (d[0])      ei = dec_pos(ei);
            else if (d[1]) ei = inc_pos(ei);
            else if (d[2]) ej = dec_pos(ej);
            else if (d[3]) ej = inc_pos(ej);
            pulse(d[0], d[1], d[2], d[3], 1'b0);
            checks++;
            if (i_actual !== 3'(ei) || j_actual !== 3'(ej)) begin
                errors++;
                $display("FAIL cursor_move n=%0d btn=%b: cur=(%0d,%0d) want (%0d,%0d)",
                         n, d, i_actual, j_actual, ei, ej);
            end
        end
        idx = 5*ei + ej;
        pulse(1, 1, 1, 1, 1);
        checks++;
        if (i_actual !== 3'(ei) || j_actual !== 3'(ej)) begin
            errors++;
            $display("FAIL fire_priority: cur=(%0d,%0d) want (%0d,%0d)", i_actual, j_actual, ei, ej);
        end
        @(negedge clk);
        model_p[idx] = (model_p[idx] == 1) ? 3 : 2;
        checks++;
        if (diff_p() != 0 || turn !== 1'b1) begin
            errors++;
            $display("FAIL fire_cursor_cell: cell=%0d diff=%0d turn=%b want cell=%0d turn=1",
                     tab_p[ei][ej], diff_p(), turn, model_p[idx]);
        end
    endtask

    task automatic test_refire();
        logic [24:0] pm, cm;
        int n;
        do_reset();
        pm = 25'($urandom) | 25'h1F;
        cm = (25'($urandom) & ~(25'd1 << 6)) | 25'h1;
        start_game(pm, cm);
        load_model(pm, cm);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        @(negedge clk);
        model_p[6] = 2;
        checks++;
        if (tab_p[1][1] !== 2'd2 || turn !== 1'b1 || diff_p() != 0) begin
            errors++;
            $display("FAIL water_shot: cell=%0d turn=%b diff=%0d want 2 1 0", tab_p[1][1], turn, diff_p());
        end
        n = 0;
        while (turn === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (turn !== 0 || timeout_left !== 30'(TT) || i_actual !== 3'd1 || j_actual !== 3'd1) begin
            errors++;
            $display("FAIL refire_setup: turn=%b to=%0d cur=(%0d,%0d) want 0 %0d (1,1)",
                     turn, timeout_left, i_actual, j_actual, TT);
        end
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (tab_p[1][1] !== 2'd2 || turn !== 0 || timeout_left !== 30'(TT - 1)) begin
            errors++;
            $display("FAIL refire_ignored: cell=%0d turn=%b to=%0d want 2 0 %0d",
                     tab_p[1][1], turn, timeout_left, TT - 1);
        end
        @(negedge clk);
        checks++;
        if (tab_p[1][1] !== 2'd2 || turn !== 0 || timeout_left !== 30'(TT - 2) || diff_p() != 0) begin
            errors++;
            $display("FAIL refire_still_turn: cell=%0d turn=%b to=%0d want 2 0 %0d",
                     tab_p[1][1], turn, timeout_left, TT - 2);
        end
    endtask

    task automatic test_win_and_restart();
        logic [24:0] pm, cm;
        do_reset();
        pm = 25'($urandom) | 25'h3;
        start_game(pm, 25'h1);
        load_model(pm, 25'h1);
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (tab_p[0][0] !== 2'd1 || game_state !== 2'd1) begin
            errors++;
            $display("FAIL win_shot_latency: cell=%0d gs=%0d want 1 1", tab_p[0][0], game_state);
        end
        @(negedge clk);
        model_p[0] = 3;
        checks++;
        if (tab_p[0][0] !== 2'd3 || game_state !== 2'd2 || turn !== 0) begin
            errors++;
            $display("FAIL win: cell=%0d gs=%0d turn=%b want 3 2 0", tab_p[0][0], game_state, turn);
        end
        for (int n = 0; n < 8; n++) begin
            logic [4:0] b;
            b = 5'($urandom_range(0, 31));
            pulse(b[0], b[1], b[2], b[3], b[4]);
            checks++;
            if (game_state !== 2'd2 || diff_p() != 0 || diff_j() != 0 ||
                i_actual !== 0 || j_actual !== 0)
            begin
                errors++;
                $display("FAIL win_frozen n=%0d: gs=%0d dp=%0d dj=%0d cur=(%0d,%0d) want frozen",
                         n, game_state, diff_p(), diff_j(), i_actual, j_actual);
            end
        end
        pm = 25'($urandom) | 25'h3;
        cm = 25'($urandom) | 25'h3;
        start_game(pm, cm);
        load_model(pm, cm);
        checks++;
        if (game_state !== 2'd1 || turn !== 0 || timeout_left !== 30'(TT) ||
            diff_j() != 0 || diff_p() != 0 || i_actual !== 0 || j_actual !== 0)
        begin
            errors++;
            $display("FAIL restart: gs=%0d turn=%b to=%0d dj=%0d dp=%0d want fresh game",
                     game_state, turn, timeout_left, diff_j(), diff_p());
        end
    endtask

    task automatic test_lose();
        logic [24:0] pm, cm;
        logic prev_turn, done, reached, fell;
        int p, shots, budget, nd, last_idx, exp_code, exp_gs;
        do_reset();
        p = $urandom_range(0, 24);
        pm = 25'd1 << p;
        cm = 25'($urandom) | 25'h1;
        start_game(pm, cm);
        load_model(pm, cm);
        shots = 0; budget = 0; done = 0; reached = 0;
        prev_turn = turn;
        while (!done && budget < 5000) begin
            @(negedge clk);
            budget++;
            nd = 0; last_idx = 0;
            for (int k = 0; k < 25; k++) begin
                if (tab_j[k/5][k%5] !== 2'(model_j[k])) begin
                    nd++;
                    last_idx = k;
                end
            end
            fell = (prev_turn === 1'b1 && turn === 1'b0);
            if (fell || nd != 0) begin
                exp_code = (model_j[last_idx] == 1) ? 3 : 2;
                checks++;
                if (nd != 1 || !fell || model_j[last_idx] >= 2 ||
                    tab_j[last_idx/5][last_idx%5] !== 2'(exp_code))
                begin
                    errors++;
                    $display("FAIL pc_shot: changed=%0d turn_fell=%b cell=%0d got=%0d want one fresh cell -> %0d",
                             nd, fell, last_idx, tab_j[last_idx/5][last_idx%5], exp_code);
                    done = 1;
                end else begin
                    model_j[last_idx] = exp_code;
                    shots++;
                    exp_gs = (last_idx == p) ? 3 : 1;
                    checks++;
                    if (game_state !== 2'(exp_gs)) begin
                        errors++;
                        $display("FAIL lose_state: shot=%0d cell=%0d gs=%0d want %0d",
                                 shots, last_idx, game_state, exp_gs);
                        done = 1;
                    end else if (last_idx == p) begin
                        reached = 1;
                        done = 1;
                    end
                end
            end
            prev_turn = turn;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL lose_reached: cycles=%0d shots=%0d gs=%0d want lose", budget, shots, game_state);
        end
        checks++;
        if (shots > 25 || diff_p() != 0) begin
            errors++;
            $display("FAIL lose_totals: shots=%0d pc_board_diff=%0d want <=25 and 0", shots, diff_p());
        end
    endtask

    initial begin
        test_reset();
        test_start_ignored();
        test_timeout_pc_shot();
        test_cursor();
        test_refire();
        test_win_and_restart();
        test_lose();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/battleship_turn_ctrl.md
Name: battleship_turn_ctrl

Overview:
- Game sequencer for the 5x5 two-board VGA battleship display.
- Owns both board state arrays and the player cursor (i_actual, j_actual) that videoGen renders.
- Alternates player and PC turns: player aims and fires via debounced single-cycle button pulses; the PC fires from an internal LFSR after a visible delay.
- Enforces a per-turn timeout and detects win/lose.

Parameters:
- TURN_TIMEOUT, 750000000, player-turn length in clk cycles (15 s at 50 MHz); counter width 30 bits.
- PC_DELAY, 25000000, cycles the PC waits before firing.
- LFSR_SEED, 5'h15, nonzero reset value of the 5-bit PC target LFSR.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; latches ship masks and begins a game
- ships_player  in  25  player ship mask; bit 5*i+j set = ship at row i, col j
- ships_pc  in  25  PC ship mask, same encoding
- btn_up, btn_down, btn_left, btn_right, btn_fire  in  1 each  single-cycle pulses, already debounced upstream
- i_actual  out  3  cursor row 0..4
- j_actual  out  3  cursor col 0..4
- tablero_jugador  out  2 x [5][5]  player board cells
- tablero_pc  out  2 x [5][5]  PC board cells
- turn  out  1  0 = player, 1 = PC
- game_state  out  2  0 idle, 1 playing, 2 win, 3 lose
- timeout_left  out  30  remaining player-turn cycles

Behaviour:
- Cell codes: 0 water, 1 ship, 2 miss, 3 hit.
- Reset: all cells 0, cursor (0,0), turn 0, game_state 0, timeout_left 0, hit counters 0, LFSR = LFSR_SEED, FSM = IDLE.
- Reset mid-game aborts immediately to the reset values.
- FSM states: IDLE, P_TURN, P_SHOT, PC_WAIT, PC_PICK, PC_SHOT, WIN, LOSE.
- IDLE:
  - start loads each board cell as 1 where the mask bit is set, else 0.
  - Ship counts = popcount of each mask; cursor set to (0,0).
  - Next state P_TURN; timeout_left = TURN_TIMEOUT.
  - start with either mask all-zero is ignored; FSM stays in IDLE.
- P_TURN:
  - Direction pulse moves the cursor one cell; at an edge the cursor saturates (see optional feature).
  - Simultaneous direction pulses: priority up > down > left > right.
  - btn_fire takes priority over direction in the same cycle.
  - Fire on a tablero_pc cell of code 0 or 1 goes to P_SHOT.
  - Fire on a cell of code 2 or 3 is ignored; remain in P_TURN with the timer still running.
  - timeout_left decrements each cycle. On reaching 0: no shot, go to PC_WAIT.
- P_SHOT (1 cycle):
  - Target cell becomes 1 -> 3 (player hit counter +1) or 0 -> 2.
  - If player hits == PC ship count, go to WIN; else go to PC_WAIT.
- PC_WAIT:
  - turn = 1; buttons ignored; counter runs PC_DELAY cycles, then go to PC_PICK.
- PC_PICK:
  - LFSR (x^5+x^3+1) steps every cycle while in this state.
  - Candidate idx = LFSR mod 25. If tablero_jugador[idx/5][idx%5] is 0 or 1, latch it and go to PC_SHOT.
  - Otherwise step the LFSR and retry. After 25 failed tries, linear-scan from idx upward mod 25; guaranteed to terminate because an unshot cell exists while the game is live.
- PC_SHOT (1 cycle):
  - Cell updated 1 -> 3 (PC hit counter +1) or 0 -> 2.
  - If PC hits == player ship count, go to LOSE.
  - Else go to P_TURN with turn = 0 and timeout_left = TURN_TIMEOUT.
- WIN/LOSE:
  - game_state 2/3; boards frozen; start returns to IDLE behaviour (reloads and restarts).
- game_state = 1 in every state except IDLE/WIN/LOSE.
- All outputs registered; a board update is visible the cycle after the shot state.

Optional Feature:
- Macro CURSOR_WRAP_EN.
- Defined: cursor wraps at edges (0 up -> 4, 4 down -> 0, same for columns).
- Undefined: cursor saturates at 0 and 4.

Test Plan:
- TURN_TIMEOUT=20, PC_DELAY=4. Reset mid-P_TURN -> every cell 0, cursor (0,0), game_state 0, turn 0 while rst is high and after release.
- ships_pc bit 0 only; start; btn_fire at (0,0) -> tablero_pc[0][0]=3, then game_state=2 and board frozen.
- Cursor at (0,0): btn_up, then btn_left -> stays (0,0). With CURSOR_WRAP_EN -> (4,0), then (4,4).
- Fire on (1,1) water -> cell=2. Next player turn, fire on (1,1) again -> ignored, state stays P_TURN, cell stays 2.
- No buttons for 20 cycles -> turn=1. PC_DELAY+pick later, exactly one tablero_jugador cell changes to 2 or 3, then turn=0 and timeout_left=20.
- ships_player one ship; player never fires -> PC eventually hits it, game_state=3; across the game the PC never targets the same cell twice.
